// File: rtl/smg_zuhe_drv_pkg.sv
// smg_zuhe_drv_pkg: shared constants and frame builder for the seven-segment driver
//   FRAME_BITS : bits per serial frame (two cascaded 74HC595)
//   STCP_PHASE : slot phase at which the storage clock pulses
//   DIGITS     : number of multiplexed digits
//   SEG_LUT    : active-low common-anode decode, dp off
package smg_zuhe_drv_pkg;
    localparam int FRAME_BITS = 16;
    localparam int STCP_PHASE = 33;
    localparam int DIGITS = 4;
    localparam logic [15:0][7:0] SEG_LUT = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };
    // {seg, sel}: seg goes to the far 595 because it is shifted first
    function automatic logic [FRAME_BITS-1:0] mk_frame(input logic [15:0] disp, input logic [1:0] dig);
        logic [3:0] nib;
        nib = disp[{dig, 2'b00} +: 4];
        return {SEG_LUT[nib], ~(8'h01 << dig)};
    endfunction
endpackage

// File: rtl/smg_zuhe_drv_if.sv
// smg_zuhe_drv_if: value-load and 595 serial-pin bundle
//   smg_mul_data/smg_mul_update : 16-bit hex value and its one-cycle load strobe
//   ds_data/ds_shcp/ds_stcp     : 595 serial data, shift clock, storage clock
interface smg_zuhe_drv_if;
    logic [15:0] smg_mul_data;
    logic smg_mul_update;
    logic ds_data;
    logic ds_shcp;
    logic ds_stcp;
    modport master(output smg_mul_data, smg_mul_update, input ds_data, ds_shcp, ds_stcp);
    modport slave(input smg_mul_data, smg_mul_update, output ds_data, ds_shcp, ds_stcp);
endinterface

// File: rtl/smg_zuhe_drv_hc595_tx.sv
// smg_zuhe_drv_hc595_tx: 16-bit MSB-first serializer for two cascaded 74HC595
//   clk, rst : clock, synchronous active-high reset
//   frame    : word loaded when start is high
//   start    : one-cycle strobe beginning a frame
//   ds_*     : registered serial data, shift clock, storage clock
module smg_zuhe_drv_hc595_tx
    import smg_zuhe_drv_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FRAME_BITS-1:0] frame,
    input  logic                  start,
    output logic                  ds_data,
    output logic                  ds_shcp,
    output logic                  ds_stcp
);
    localparam logic [5:0] SP = 6'(STCP_PHASE);
    // ph tracks the slot phase: odd phases present a bit, even phases raise shcp
    logic [5:0] ph_q, ph_d;
    logic [FRAME_BITS-1:0] sh_q, sh_d;
    logic data_q, data_d, shcp_q, shcp_d, stcp_q, stcp_d, shift;
    always_comb begin
        shift  = ph_q[0] && ph_q != SP;
        ph_d   = start ? 6'd1 : (ph_q == '0 || ph_q == SP) ? '0 : ph_q + 6'd1;
        sh_d   = start ? frame : shift ? {sh_q[FRAME_BITS-2:0], 1'b0} : sh_q;
        data_d = shift ? sh_q[FRAME_BITS-1] : data_q;
        shcp_d = ph_q != '0 && !ph_q[0];
        stcp_d = ph_q == SP;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            ph_q   <= '0;
            sh_q   <= '0;
            data_q <= 1'b0;
            shcp_q <= 1'b0;
            stcp_q <= 1'b0;
        end else begin
            ph_q   <= ph_d;
            sh_q   <= sh_d;
            data_q <= data_d;
            shcp_q <= shcp_d;
            stcp_q <= stcp_d;
        end
    end
    assign ds_data = data_q;
    assign ds_shcp = shcp_q;
    assign ds_stcp = stcp_q;
endmodule

// File: rtl/smg_zuhe_drv.sv
// smg_zuhe_drv: four-digit hex seven-segment driver over two cascaded 74HC595
//   MAX_CNT : clock cycles per digit slot (>= 40)
//   clk     : clock
//   rst_n   : synchronous reset, 1 = reset (name kept for board compatibility)
//   bus     : value load inputs and 595 serial outputs
module smg_zuhe_drv
    import smg_zuhe_drv_pkg::*;
#(
    parameter int MAX_CNT = 50000
) (
    input logic           clk,
    input logic           rst_n,
    smg_zuhe_drv_if.slave bus
);
    localparam int CW = $clog2(MAX_CNT);
    logic [CW-1:0] cnt_q, cnt_d;
    logic [$clog2(DIGITS)-1:0] dig_q, dig_d;
    logic [15:0] disp_q, disp_d;
    logic [FRAME_BITS-1:0] frame;
    logic wrap;
    always_comb begin
        wrap   = cnt_q == CW'(MAX_CNT - 1);
        cnt_d  = wrap ? '0 : cnt_q + CW'(1);
        dig_d  = wrap ? dig_q + 2'd1 : dig_q;
        disp_d = bus.smg_mul_update ? bus.smg_mul_data : disp_q;
        frame  = mk_frame(disp_q, dig_q);
    end
    always_ff @(posedge clk) begin
        if (rst_n) begin
            cnt_q  <= '0;
            dig_q  <= '0;
            disp_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            dig_q  <= dig_d;
            disp_q <= disp_d;
        end
    end
    // snapshot at cnt 0 uses the pre-update disp, so a strobe never alters a frame in flight
    smg_zuhe_drv_hc595_tx u_hc595_tx (
        .clk    (clk),
        .rst    (rst_n),
        .frame  (frame),
        .start  (cnt_q == '0),
        .ds_data(bus.ds_data),
        .ds_shcp(bus.ds_shcp),
        .ds_stcp(bus.ds_stcp)
    );
endmodule

// File: tb/tb_smg_zuhe_drv.sv
// tb_smg_zuhe_drv: scoreboard bench for smg_zuhe_drv
module tb_smg_zuhe_drv;
    localparam int MAX_CNT = 50;
    localparam logic [7:0] SEG_TAB [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0;
    int n_fail = 0;
    smg_zuhe_drv_if bus();
    smg_zuhe_drv #(.MAX_CNT(MAX_CNT)) dut (.clk(clk), .rst_n(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_frame(input logic [15:0] d, input int g);
        logic [3:0] n;
        logic [7:0] sel;
        n = d[4*g +: 4];
        sel = 8'hFF;
        sel[g] = 1'b0;
        return {SEG_TAB[n], sel};
    endfunction

    // reference model of the slot timing; expected frames queued at each capture
    int m_cnt = 0;
    int m_dig = 0;
    logic [15:0] m_disp = '0;
    logic m_rst = 1'b1;
    logic [15:0] exp_q[$];
    logic [15:0] obs[$];
    always @(posedge clk) begin
        m_rst <= rst;
        if (rst) begin
            m_cnt <= 0;
            m_dig <= 0;
            m_disp <= '0;
            exp_q.delete();
        end else begin
            if (m_cnt == 0) exp_q.push_back(exp_frame(m_disp, m_dig));
            if (bus.smg_mul_update) m_disp <= bus.smg_mul_data;
            m_cnt <= (m_cnt == MAX_CNT - 1) ? 0 : m_cnt + 1;
            if (m_cnt == MAX_CNT - 1) m_dig <= (m_dig + 1) % 4;
        end
    end

    // pin monitor: rebuilds frames from shcp edges and checks protocol
    logic p_shcp = 1'b0, p_stcp = 1'b0, p_data = 1'b0;
    logic [15:0] fr = '0;
    int nb = 0;
    always @(negedge clk) begin
        if (m_rst) begin
            chk("rst_data", 32'(bus.ds_data), 0);
            chk("rst_shcp", 32'(bus.ds_shcp), 0);
            chk("rst_stcp", 32'(bus.ds_stcp), 0);
            nb <= 0;
            p_shcp <= 1'b0;
            p_stcp <= 1'b0;
            p_data <= 1'b0;
        end else begin
            if (bus.ds_shcp && !p_shcp) begin
                chk("data_stable", 32'(bus.ds_data), 32'(p_data));
                fr <= {fr[14:0], bus.ds_data};
                nb <= nb + 1;
            end
            if (bus.ds_stcp) begin
                chk("stcp_width", 32'(p_stcp), 0);
                chk("stcp_after_shcp", 32'({p_shcp, bus.ds_shcp}), 32'h2);
                chk("nbits", 32'(nb), 16);
                chk("q_size", 32'(exp_q.size()), 1);
                if (exp_q.size() > 0) chk("frame", 32'(fr), 32'(exp_q.pop_front()));
                obs.push_back(fr);
                nb <= 0;
            end
            p_shcp <= bus.ds_shcp;
            p_stcp <= bus.ds_stcp;
            p_data <= bus.ds_data;
        end
    end

    task automatic strobe(input logic [15:0] v);
        @(posedge clk);
        #1;
        bus.smg_mul_data = v;
        bus.smg_mul_update = 1'b1;
        @(posedge clk);
        #1;
        bus.smg_mul_update = 1'b0;
    endtask

    task automatic wait_obs(input int n, input string tag);
        int t = 0;
        while (obs.size() < n && t < 20 * MAX_CNT) begin
            @(posedge clk);
            t++;
        end
        chk(tag, 32'(obs.size() >= n), 1);
    endtask

    task automatic wait_cnt(input int c);
        int t = 0;
        while (m_cnt != c && t < 4 * MAX_CNT) begin
            @(posedge clk);
            t++;
        end
        chk("wait_cnt", 32'(m_cnt == c), 1);
    endtask

    initial begin
        logic [15:0] seq [5] = '{16'h82FD, 16'hB0FB, 16'hF9F7, 16'hA4FE, 16'h82FD};
        bus.smg_mul_data = '0;
        bus.smg_mul_update = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        wait_obs(1, "timeout_first");
        if (obs.size() >= 1) chk("first_frame", 32'(obs[0]), 32'hC0FE);
        strobe(16'h1362);
        obs.delete();
        wait_obs(5, "timeout_1362");
        for (int i = 0; i < 5; i++)
            if (obs.size() > i) chk($sformatf("seq1362_%0d", i), 32'(obs[i]), 32'(seq[i]));
        wait_cnt(15);
        obs.delete();
        strobe(16'hFFFF);
        wait_obs(2, "timeout_ffff");
        if (obs.size() >= 2) begin
            chk("ffff_current", 32'(obs[0]), 32'hB0FB);
            chk("ffff_next", 32'(obs[1]), 32'h8EF7);
        end
        wait_cnt(10);
        obs.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        wait_obs(1, "timeout_rst");
        if (obs.size() >= 1) chk("after_rst", 32'(obs[0]), 32'hC0FE);
        for (int v = 0; v < 16; v++) begin
            strobe({4{4'(v)}});
            obs.delete();
            wait_obs(2, "timeout_walk");
            if (obs.size() >= 2) chk($sformatf("seg_%0h", v), 32'(obs[1][15:8]), 32'(SEG_TAB[v]));
        end
        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
